// File: rtl/neuron_stream_loader.sv
// ============================================================================
// Module   : neuron_stream_loader
// Brief    : Serial (weight, input) stream to packed neuron operand buses.
//            Drives a two-cycle neuron enable and flags the finished result.
//            Option macro NEURON_LOADER_DBUF_EN adds a shadow load bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module neuron_stream_loader #(
    parameter int N            = 64,
    parameter int N_INPUTS     = 16,
    parameter int LOG_N_INPUTS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [N-1:0]          s_w,
    input  logic [N-1:0]          s_x,
    input  logic                  s_last,
    output logic [N*N_INPUTS-1:0] W_out,
    output logic [N*N_INPUTS-1:0] X_out,
    output logic                  en_out,
    output logic                  out_valid,
    output logic                  err_len,
    output logic                  busy
);

    localparam int                      c_bus_w    = N * N_INPUTS;
    localparam logic [LOG_N_INPUTS-1:0] c_last_idx = LOG_N_INPUTS'(N_INPUTS - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FIRE0 = 2'd1,
        ST_FIRE1 = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [LOG_N_INPUTS-1:0] r_count;
    logic [c_bus_w-1:0]      r_w_act;
    logic [c_bus_w-1:0]      r_x_act;
    logic                    r_en;
    logic                    r_out_valid;
    logic                    r_err_len;

    logic w_xfer;
    logic w_vec_end;
    logic w_len_bad;
    logic w_fire_start;
    logic w_err_src;

    assign w_xfer    = s_valid && s_ready;
    assign w_vec_end = w_xfer && (s_last || (r_count == c_last_idx));
    // A length error is an s_last that disagrees with the slot position.
    assign w_len_bad = s_last ^ (r_count == c_last_idx);

`ifdef NEURON_LOADER_DBUF_EN
    logic [c_bus_w-1:0] r_w_ld;
    logic [c_bus_w-1:0] r_x_ld;
    logic               r_ld_full;
    logic               r_ld_err;
    logic [c_bus_w-1:0] w_w_merge;
    logic [c_bus_w-1:0] w_x_merge;
    logic               w_can_fire;

    assign s_ready = !r_ld_full;

    // Load bank with this cycle's element folded in, so a vector finishing
    // while the FSM can fire goes straight to the active bank.
    always_comb begin
        w_w_merge = r_w_ld;
        w_x_merge = r_x_ld;
        if (w_xfer) begin
            w_w_merge[r_count*N +: N] = s_w;
            w_x_merge[r_count*N +: N] = s_x;
        end
    end

    assign w_can_fire   = (r_state == ST_LOAD) || (r_state == ST_DONE);
    assign w_fire_start = w_can_fire && (r_ld_full || w_vec_end);
    assign w_err_src    = r_ld_full ? r_ld_err : w_len_bad;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_w_act   <= '0;
            r_x_act   <= '0;
            r_w_ld    <= '0;
            r_x_ld    <= '0;
            r_ld_full <= 1'b0;
            r_ld_err  <= 1'b0;
            r_count   <= '0;
        end else begin
            if (w_fire_start) begin
                r_w_act   <= r_ld_full ? r_w_ld : w_w_merge;
                r_x_act   <= r_ld_full ? r_x_ld : w_x_merge;
                r_w_ld    <= '0;
                r_x_ld    <= '0;
                r_ld_full <= 1'b0;
                r_ld_err  <= 1'b0;
            end else begin
                if (r_state == ST_DONE) begin
                    r_w_act <= '0;
                    r_x_act <= '0;
                end
                if (w_xfer) begin
                    r_w_ld <= w_w_merge;
                    r_x_ld <= w_x_merge;
                end
                if (w_vec_end) begin
                    r_ld_full <= 1'b1;
                    r_ld_err  <= w_len_bad;
                end
            end
            if (w_xfer) begin
                r_count <= w_vec_end ? '0 : r_count + 1'b1;
            end
        end
    end
`else
    assign s_ready      = (r_state == ST_LOAD);
    assign w_fire_start = w_vec_end;
    assign w_err_src    = w_len_bad;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_w_act <= '0;
            r_x_act <= '0;
            r_count <= '0;
        end else begin
            if (w_xfer) begin
                r_w_act[r_count*N +: N] <= s_w;
                r_x_act[r_count*N +: N] <= s_x;
                r_count <= w_vec_end ? '0 : r_count + 1'b1;
            end
            // Zeroed slices make a short next vector contribute nothing extra.
            if (r_state == ST_DONE) begin
                r_w_act <= '0;
                r_x_act <= '0;
            end
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD:  w_state_nxt = w_fire_start ? ST_FIRE0 : ST_LOAD;
            ST_FIRE0: w_state_nxt = ST_FIRE1;
            ST_FIRE1: w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = w_fire_start ? ST_FIRE0 : ST_LOAD;
            default:  w_state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_LOAD;
            r_en        <= 1'b0;
            r_out_valid <= 1'b0;
            r_err_len   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_en        <= (w_state_nxt == ST_FIRE0) || (w_state_nxt == ST_FIRE1);
            r_out_valid <= (w_state_nxt == ST_DONE);
            r_err_len   <= w_fire_start && w_err_src;
        end
    end

    assign W_out     = r_w_act;
    assign X_out     = r_x_act;
    assign en_out    = r_en;
    assign out_valid = r_out_valid;
    assign err_len   = r_err_len;
    assign busy      = (r_state != ST_LOAD);

endmodule

`default_nettype wire
